// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI frame receiver: FSM state encoding,
// the default lane-group count and a counter width helper.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_HIGH = 2'd2
  } state_e;

  localparam int SPI_BITS_DFLT = 2;
  localparam int GROUPS        = 8 / SPI_BITS_DFLT;

  // Smallest width (at least 1) able to hold the values 0 .. n-1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// Pin and handler bundle of spi_frame_rx; slave is the receiver's view,
// master the view of whoever drives the SPI pins and supplies reply bytes.
interface spi_frame_rx_if #(
  parameter int SPI_BITS = 2
);
  logic [SPI_BITS-1:0] sdi;
  logic [SPI_BITS-1:0] sdo;
  logic                sclk;
  logic                sncs;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_first;
  logic                tx_req;
  logic [7:0]          tx_data;
  logic                frame_start;
  logic                frame_end;
  logic                frame_err;

  modport slave (
    input  sdi, sclk, sncs, tx_data,
    output sdo, rx_data, rx_valid, rx_first, tx_req,
           frame_start, frame_end, frame_err
  );

  modport master (
    output sdi, sclk, sncs, tx_data,
    input  sdo, rx_data, rx_valid, rx_first, tx_req,
           frame_start, frame_end, frame_err
  );
endinterface

// File: rtl/sync_ff.sv
// Two-flop synchroniser of parameterised width with a selectable reset value.
module sync_ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
endmodule

// File: rtl/spi_frame_rx.sv
// Oversampling multi-lane SPI slave (mode 0): deserialises sdi into bytes and
// serialises reply bytes onto sdo. Optional sclk inactivity abort: SPI_TIMEOUT_EN.
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int SPI_BITS       = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           nreset,
  spi_frame_rx_if.slave  bus
);
  localparam int            NGROUPS  = 8 / SPI_BITS;
  localparam int            CW       = cnt_width(NGROUPS);
  localparam logic [CW-1:0] LAST_GRP = CW'(NGROUPS - 1);

  logic                sclk_s, sncs_s;
  logic [SPI_BITS-1:0] sdi_s;
  logic                sclk_d_r, sncs_d_r;
  logic                sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
  logic [7:0]          rx_next_s;

  state_e              state_r;
  logic [CW-1:0]       cnt_r;
  logic [7:0]          rx_sr_r, tx_sr_r, rx_data_r;
  logic                first_r, reload_r;
  logic [SPI_BITS-1:0] sdo_r;
  logic                rx_valid_r, rx_first_r, tx_req_r;
  logic                frame_start_r, frame_end_r, frame_err_r;

  sync_ff #(.W(1), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .nreset(nreset), .d(bus.sclk), .q(sclk_s));
  // sncs resets to "selected" so a reset released mid-frame lands in WAIT_HIGH.
  sync_ff #(.W(1), .RST_VAL(1'b0)) u_sync_sncs (.clk(clk), .nreset(nreset), .d(bus.sncs), .q(sncs_s));
  sync_ff #(.W(SPI_BITS), .RST_VAL({SPI_BITS{1'b0}})) u_sync_sdi (.clk(clk), .nreset(nreset), .d(bus.sdi), .q(sdi_s));

  // Delay stage for edge detection on the synchronised sclk and sncs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sclk_d_r <= 1'b0;
      sncs_d_r <= 1'b0;
    end else begin
      sclk_d_r <= sclk_s;
      sncs_d_r <= sncs_s;
    end
  end

  assign sclk_rise_s = sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_s & sclk_d_r;
  assign cs_rise_s   = sncs_s & ~sncs_d_r;
  assign cs_fall_s   = ~sncs_s & sncs_d_r;
  assign rx_next_s   = 8'({rx_sr_r, sdi_s});

`ifdef SPI_TIMEOUT_EN
  localparam int            IW      = (cnt_width(TIMEOUT_CYCLES) < 12) ? 12 : cnt_width(TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT_CYCLES - 1);
  logic [IW-1:0] idle_cnt_r;
  logic          timeout_s;

  // Counts clk cycles without an sclk edge while a frame is being shifted.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idle_cnt_r <= '0;
    end else if ((state_r != SHIFT) || sclk_rise_s || sclk_fall_s) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_r + IW'(1);
    end
  end

  assign timeout_s = (idle_cnt_r == TO_LAST);
`else
  logic timeout_s;
  assign timeout_s = 1'b0;
`endif

  // Frame FSM with shift registers and all registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r       <= WAIT_HIGH;
      cnt_r         <= '0;
      rx_sr_r       <= 8'h00;
      tx_sr_r       <= 8'h00;
      first_r       <= 1'b0;
      reload_r      <= 1'b0;
      rx_data_r     <= 8'h00;
      sdo_r         <= '1;
      rx_valid_r    <= 1'b0;
      rx_first_r    <= 1'b0;
      tx_req_r      <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      rx_valid_r    <= 1'b0;
      rx_first_r    <= 1'b0;
      tx_req_r      <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      frame_err_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            state_r       <= SHIFT;
            frame_start_r <= 1'b1;
            tx_req_r      <= 1'b1;
            sdo_r         <= tx_data_msb(bus.tx_data);
            tx_sr_r       <= bus.tx_data << SPI_BITS;
            cnt_r         <= '0;
            first_r       <= 1'b1;
            reload_r      <= 1'b0;
          end else begin
            state_r <= IDLE;
            sdo_r   <= '1;
          end
        end
        SHIFT: begin
          if (cs_rise_s) begin
            state_r     <= IDLE;
            frame_end_r <= 1'b1;
            sdo_r       <= '1;
            cnt_r       <= '0;
            reload_r    <= 1'b0;
            if (sclk_rise_s && (cnt_r == LAST_GRP)) begin
              rx_data_r  <= rx_next_s;
              rx_valid_r <= 1'b1;
              rx_first_r <= first_r;
            end else begin
              frame_err_r <= (cnt_r != '0) || sclk_rise_s;
            end
          end else if (timeout_s) begin
            state_r     <= WAIT_HIGH;
            frame_end_r <= 1'b1;
            frame_err_r <= 1'b1;
            sdo_r       <= '1;
          end else begin
            state_r <= SHIFT;
            if (sclk_rise_s) begin
              rx_sr_r <= rx_next_s;
              if (cnt_r == LAST_GRP) begin
                cnt_r      <= '0;
                rx_data_r  <= rx_next_s;
                rx_valid_r <= 1'b1;
                rx_first_r <= first_r;
                first_r    <= 1'b0;
                reload_r   <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CW'(1);
              end
            end else if (sclk_fall_s) begin
              if (reload_r) begin
                tx_req_r <= 1'b1;
                sdo_r    <= tx_data_msb(bus.tx_data);
                tx_sr_r  <= bus.tx_data << SPI_BITS;
                reload_r <= 1'b0;
              end else begin
                sdo_r   <= tx_data_msb(tx_sr_r);
                tx_sr_r <= tx_sr_r << SPI_BITS;
              end
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        WAIT_HIGH: begin
          sdo_r <= '1;
          if (sncs_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_HIGH;
          end
        end
        default: begin
          state_r <= WAIT_HIGH;
          sdo_r   <= '1;
        end
      endcase
    end
  end

  function automatic logic [SPI_BITS-1:0] tx_data_msb(input logic [7:0] b);
    return b[7 -: SPI_BITS];
  endfunction

  assign bus.sdo         = sdo_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.rx_first    = rx_first_r;
  assign bus.tx_req      = tx_req_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_end   = frame_end_r;
  assign bus.frame_err   = frame_err_r;
endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: random and directed frames against a
// byte-level model of the SPI transfer; timeout scenario under SPI_TIMEOUT_EN.
module tb_spi_frame_rx;
  localparam int SPI_BITS = 2;
  localparam int GROUPS   = 8 / SPI_BITS;
  localparam int HALF     = 4;
`ifdef SPI_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif

  typedef struct { logic [7:0] data; logic first; } rx_exp_t;
  typedef struct { logic err; int ntx; } end_exp_t;

  logic clk;
  logic nreset;
  spi_frame_rx_if #(.SPI_BITS(SPI_BITS)) bus ();

  spi_frame_rx #(.SPI_BITS(SPI_BITS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nreset(nreset), .bus(bus)
  );

  int checks;
  int failures;
  rx_exp_t             exp_rx[$];
  end_exp_t            exp_end[$];
  logic [SPI_BITS-1:0] exp_sdo[$];
  int                  exp_start;
  int                  txreq_cnt;
  logic [7:0]          sbytes[$];
  logic [7:0]          rbytes[$];
  int                  tx_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [SPI_BITS-1:0] grp(input logic [7:0] b, input int g);
    return SPI_BITS'(b >> (8 - SPI_BITS * (g + 1)));
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_groups(input int first_g, input int n);
    for (int j = first_g; j < first_g + n; j++) begin
      bus.sdi = grp(sbytes[j / GROUPS], j % GROUPS);
      clks(HALF);
      bus.sclk = 1'b1;
      clks(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  // Full frame of ngroups lane groups from sbytes, replying with rbytes.
  task automatic do_frame(input int ngroups);
    int nfull;
    nfull = ngroups / GROUPS;
    exp_start++;
    for (int i = 0; i < nfull; i++) exp_rx.push_back('{data: sbytes[i], first: (i == 0)});
    exp_end.push_back('{err: (ngroups % GROUPS) != 0, ntx: 1 + nfull});
    for (int j = 0; j < ngroups; j++) exp_sdo.push_back(grp(rbytes[j / GROUPS], j % GROUPS));
    tx_idx = 0;
    bus.tx_data = rbytes[0];
    bus.sncs = 1'b0;
    clks(8);
    send_groups(0, ngroups);
    clks(HALF);
    bus.sncs = 1'b1;
    clks(10);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sdo"},    32'(bus.sdo), 32'((1 << SPI_BITS) - 1));
    check({tag, "_rxdata"}, 32'(bus.rx_data), 32'h0);
    check({tag, "_pulses"}, 32'({bus.rx_valid, bus.rx_first, bus.tx_req,
                                 bus.frame_start, bus.frame_end, bus.frame_err}), 32'h0);
  endtask

  // Monitor: compares every DUT output event against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_valid) begin
        if (exp_rx.size() == 0) check("rx_unexpected", 32'(bus.rx_data), 32'hFFFF_FFFF);
        else begin
          rx_exp_t e;
          e = exp_rx.pop_front();
          check("rx_data", 32'(bus.rx_data), 32'(e.data));
          check("rx_first", 32'(bus.rx_first), 32'(e.first));
        end
      end
      if (bus.frame_start) begin
        check("start_expected", 32'(exp_start > 0), 32'h1);
        if (exp_start > 0) exp_start--;
      end
      if (bus.tx_req) begin
        txreq_cnt++;
        tx_idx++;
        bus.tx_data = (tx_idx < rbytes.size()) ? rbytes[tx_idx] : 8'h00;
      end
      if (bus.frame_end) begin
        if (exp_end.size() == 0) check("end_unexpected", 32'(bus.frame_err), 32'hFFFF_FFFF);
        else begin
          end_exp_t e;
          e = exp_end.pop_front();
          check("frame_err", 32'(bus.frame_err), 32'(e.err));
          check("tx_req_count", 32'(txreq_cnt), 32'(e.ntx));
          check("sdo_after_end", 32'(bus.sdo), 32'((1 << SPI_BITS) - 1));
        end
        txreq_cnt = 0;
      end
    end
  end

  // Monitor: sdo as seen by the SPI master on each sclk rise.
  initial begin
    forever begin
      @(posedge bus.sclk);
      if (exp_sdo.size() == 0) check("sdo_unexpected", 32'(bus.sdo), 32'hFFFF_FFFF);
      else check("sdo_group", 32'(bus.sdo), 32'(exp_sdo.pop_front()));
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int ng;
    checks = 0; failures = 0; exp_start = 0; txreq_cnt = 0; tx_idx = 0;
    nreset = 1'b0;
    bus.sclk = 1'b0; bus.sncs = 1'b1; bus.sdi = '0; bus.tx_data = 8'h00;
    clks(3);
    check_reset_values("reset");
    nreset = 1'b1;
    clks(6);
    check_reset_values("idle");

    // Two full bytes with known replies.
    sbytes = '{8'hA5, 8'h3C};
    rbytes = '{8'h96, 8'h0F, 8'h00, 8'h00};
    do_frame(2 * GROUPS);
    check("idle_sdo", 32'(bus.sdo), 32'((1 << SPI_BITS) - 1));

    // Partial byte then a clean frame.
    sbytes = '{8'h77};
    rbytes = '{8'hE1, 8'h00};
    do_frame(GROUPS - 1);
    sbytes = '{8'h5A};
    rbytes = '{8'h24, 8'h00, 8'h00};
    do_frame(GROUPS);

    // Reset pulse mid-frame with sncs held low.
    sbytes = '{8'hC3, 8'h00};
    rbytes = '{8'hB4, 8'h00};
    exp_start++;
    exp_sdo.push_back(grp(rbytes[0], 0));
    exp_sdo.push_back(grp(rbytes[0], 1));
    tx_idx = 0;
    bus.tx_data = rbytes[0];
    bus.sncs = 1'b0;
    clks(8);
    send_groups(0, 2);
    nreset = 1'b0;
    clks(2);
    check_reset_values("midreset");
    nreset = 1'b1;
    txreq_cnt = 0;
    for (int j = 0; j < GROUPS; j++) exp_sdo.push_back('1);
    clks(4);
    send_groups(0, GROUPS);
    check_reset_values("waithigh");
    bus.sncs = 1'b1;
    clks(10);
    sbytes = '{8'hC3};
    rbytes = '{8'h3D, 8'h00, 8'h00};
    do_frame(GROUPS);

`ifdef SPI_TIMEOUT_EN
    begin
      int cyc;
      sbytes = '{8'h81, 8'h00};
      rbytes = '{8'h42, 8'h00};
      exp_start++;
      exp_end.push_back('{err: 1'b1, ntx: 1});
      exp_sdo.push_back(grp(rbytes[0], 0));
      exp_sdo.push_back(grp(rbytes[0], 1));
      for (int j = 0; j < 2; j++) exp_sdo.push_back('1);
      tx_idx = 0;
      bus.tx_data = rbytes[0];
      bus.sncs = 1'b0;
      clks(8);
      send_groups(0, 2);
      cyc = 0;
      while (!bus.frame_end && cyc < 100) begin
        clks(1);
        cyc++;
      end
      check("timeout_cycle_window", 32'((cyc >= 60) && (cyc <= 72)), 32'h1);
      clks(2);
      send_groups(2, 2);
      bus.sncs = 1'b1;
      clks(10);
    end
`endif

    // Randomised frames, some ending in a partial byte.
    for (int f = 0; f < 12; f++) begin
      int nb;
      nb = $urandom_range(1, 3);
      sbytes.delete();
      rbytes.delete();
      for (int i = 0; i < nb; i++) sbytes.push_back(8'($urandom));
      for (int i = 0; i < nb + 2; i++) rbytes.push_back(8'($urandom));
      ng = nb * GROUPS;
      if ($urandom_range(0, 2) == 0) ng = ng - $urandom_range(1, GROUPS - 1);
      do_frame(ng);
    end

    clks(20);
    check("rx_queue_drained", 32'(exp_rx.size()), 32'h0);
    check("end_queue_drained", 32'(exp_end.size()), 32'h0);
    check("sdo_queue_drained", 32'(exp_sdo.size()), 32'h0);
    check("start_all_seen", 32'(exp_start), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
